bcd_display_driver: RTL and testbench
=====================================

# bcd_display_driver

Downstream consumer of the 7-bit synchronous down-counter output `q[6:0]`. The block continuously samples the binary count, converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a single 7-segment bus with one-hot digit enables. Values above 99 are flagged and shown as dashes.

## Interface
- `REFRESH`, default 50000: clock cycles each digit stays enabled before the mux switches digits; legal range ≥ 2.
- `BLANK_LZ`, default 1: when 1, a tens digit of 0 is blanked; when 0, it is shown as "0".
- `clk` input 1: single clock; all state changes on the rising edge.
- `clr` input 1: synchronous, active-high reset.
- `bin` input 7: binary value to display, driven by the counter `q`.
- `seg` output 7: segment drive, active-high, `seg[6]`=a … `seg[0]`=g.
- `an` output 2: digit enable, one-hot, active-high; `2'b01` = units, `2'b10` = tens.
- `valid` output 1: one-cycle pulse when new digits are committed to the display registers.
- `ovf` output 1: registered flag, 1 while the committed value is > 99.

## Operation
- The conversion FSM has three states: LOAD, SHIFT, UPDATE.
  - LOAD (1 cycle):
    - `sh <= bin`.
    - `bcd[7:0] <= 0`.
    - `hund <= 0`.
    - `cnt <= 0`.
    - Next state is SHIFT.
  - SHIFT (exactly 7 cycles):
    - Each cycle, first add 3 to every nibble of `bcd` that is ≥ 5.
    - Then shift `{hund,bcd,sh}` left by 1.
    - `cnt` increments each cycle; when `cnt` reaches 6, the next state is UPDATE.
  - UPDATE (1 cycle):
    - `units <= bcd[3:0]`, `tens <= bcd[7:4]`.
    - `ovf <= (hund != 0)`.
    - `valid <= 1`.
    - Next state is LOAD.
- The FSM runs continuously. The sample period is 9 cycles, and `bin` is sampled only in LOAD.
- Changes to `bin` between samples are ignored until the next LOAD.
- Refresh counter `rc`:
  - Counts 0 … `REFRESH-1`.
  - On wrap-around, `sel` toggles.
  - `an = sel ? 2'b10 : 2'b01`.
- Segment decode (combinational from the registered `sel`, `units`, `tens`, `ovf`):
  - `ovf=1`: both digits show a dash, `seg = 7'b0000001`.
  - Otherwise, the selected digit is decoded with this digit set: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - When `BLANK_LZ=1`, `sel=1` and `tens=0`: `seg = 7'b0000000`.
- The digit-encoding width rule is fixed: `bin` ≤ 127 never produces a BCD nibble > 9, and `hund` ≤ 1.

## Timing
- Reset values after the `clr` edge:
  - FSM = LOAD.
  - `units = tens = 0`.
  - `ovf = 0`, `valid = 0`.
  - `rc = 0`, `sel = 0`.
  - Resulting outputs: `an = 2'b01`, `seg = 7'b1111110` (units "0").
- Latency is 9 cycles. If `bin` is sampled in LOAD at edge N, `units`/`tens`/`ovf` update and `valid` is 1 after edge N+8.
  - The first `valid` pulse after reset release occurs 9 edges after the first non-reset edge.
- `valid` is high for exactly 1 cycle in every 9-cycle period.
- Digit switching: `sel` toggles every `REFRESH` cycles, so a full two-digit frame lasts 2×`REFRESH` cycles.
- The conversion FSM and the refresh mux are independent. A commit mid-digit changes `seg` immediately, on the edge after UPDATE, with no effect on `an` timing.
- Reset mid-conversion: `clr` high at any edge aborts SHIFT and restores all reset values on that edge. No `valid` is produced for the aborted sample.
- `clr` takes priority over every other event on the same edge.

## Test plan
- Reset behaviour: `REFRESH=4`, hold `clr=1` for 2 cycles, then release with `bin=0`.
  - Required: `seg=1111110`, `an=01`, `valid=0` during and immediately after reset.
  - Required: first `valid` pulse exactly 9 cycles after release.
- Conversion of 42: `bin=42`.
  - After `valid`: `units=2`, `tens=4`.
  - Units phase (`an=01`): `seg=1101101`.
  - Tens phase (`an=10`): `seg=0110011`.
  - `ovf=0`.
- Counting-down source: drive `bin` from a down-counter starting at 99, stepping every 9 cycles, aligned to LOAD.
  - Required: each `valid` shows the previous counter value as BCD (99, 98, …, 0).
- Leading-zero blanking: `bin=7`.
  - `BLANK_LZ=1`: tens phase gives `seg=0000000`.
  - `BLANK_LZ=0`: tens phase gives `seg=1111110`.
  - Units phase gives `seg=1110000` in both cases.
- Overflow: `bin=127`, then `bin=100`.
  - Required: `ovf=1` and `seg=0000001` on both digits.
  - Then `bin=99`: `ovf` clears on the next commit and the display shows "99".
- Mid-operation reset: assert `clr` for 1 cycle on the 4th SHIFT cycle of a `bin=55` conversion.
  - Required: no `valid` pulse for that sample.
  - Required: outputs return to reset values.
  - Required: the next `valid` arrives 9 cycles after release, with "55".

Source files
------------

// File: rtl/bcd_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_display_driver
//
// Purpose:
//   Samples a 7-bit binary count, converts it to two BCD digits with a
//   sequential shift-add-3 (double-dabble) engine, and time-multiplexes the
//   digits onto one 7-segment bus with one-hot digit enables. Committed values
//   above 99 raise ovf and are shown as dashes on both digits.
//
// Parameters:
//   REFRESH  - clock cycles each digit stays enabled (>= 2)
//   BLANK_LZ - 1: blank a tens digit of 0; 0: show it as "0"
//
// Ports:
//   clk   in  1  single clock, rising edge
//   clr   in  1  synchronous active-high reset, highest priority
//   bin   in  7  binary value to display (sampled once per 9-cycle period)
//   seg   out 7  segment drive, active-high, seg[6]=a ... seg[0]=g
//   an    out 2  one-hot digit enable, 2'b01 = units, 2'b10 = tens
//   valid out 1  one-cycle pulse when new digits are committed
//   ovf   out 1  high while the committed value is > 99
// -----------------------------------------------------------------------------
module bcd_display_driver #(
  parameter int REFRESH  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] bin,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       valid,
  output logic       ovf
);

  localparam int RC_W = (REFRESH > 2) ? $clog2(REFRESH) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [6:0]      r_sh;
  logic [7:0]      r_bcd;
  logic            r_hund;
  logic [2:0]      r_cnt;
  logic [3:0]      r_units;
  logic [3:0]      r_tens;
  logic            r_ovf;
  logic            r_valid;
  logic [RC_W-1:0] r_rc;
  logic            r_sel;
  logic [7:0]      w_adj;
  logic [6:0]      w_seg;

  // Double-dabble correction: a nibble >= 5 would exceed 9 after doubling.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Digit-to-segment pattern, a..g from MSB to LSB.
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  assign w_adj = {add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Conversion FSM next-state logic; seven SHIFT cycles are counted by r_cnt 0..6.
  always_comb begin
    w_state_nxt = ST_LOAD;
    case (r_state)
      ST_LOAD: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == 3'd6) begin
          w_state_nxt = ST_UPDATE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        w_state_nxt = ST_LOAD;
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Conversion datapath and committed display registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sh    <= 7'd0;
      r_bcd   <= 8'd0;
      r_hund  <= 1'b0;
      r_cnt   <= 3'd0;
      r_units <= 4'd0;
      r_tens  <= 4'd0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_sh   <= bin;
          r_bcd  <= 8'd0;
          r_hund <= 1'b0;
          r_cnt  <= 3'd0;
        end
        ST_SHIFT: begin
          // {hund, bcd, sh} shifted left by one after the add-3 correction.
          r_hund <= w_adj[7];
          r_bcd  <= {w_adj[6:0], r_sh[6]};
          r_sh   <= {r_sh[5:0], 1'b0};
          r_cnt  <= r_cnt + 3'd1;
        end
        ST_UPDATE: begin
          r_units <= r_bcd[3:0];
          r_tens  <= r_bcd[7:4];
          r_ovf   <= r_hund;
          r_valid <= 1'b1;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Refresh counter; digit select toggles on every wrap, independent of the FSM.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rc  <= {RC_W{1'b0}};
      r_sel <= 1'b0;
    end else if (r_rc == RC_MAX) begin
      r_rc  <= {RC_W{1'b0}};
      r_sel <= ~r_sel;
    end else begin
      r_rc  <= r_rc + RC_W'(1);
    end
  end

  // Segment decode from the registered select, digits and overflow flag.
  always_comb begin
    w_seg = 7'b0000000;
    if (r_ovf) begin
      w_seg = 7'b0000001;
    end else if (r_sel) begin
      if (BLANK_LZ && (r_tens == 4'd0)) begin
        w_seg = 7'b0000000;
      end else begin
        w_seg = digit_seg(r_tens);
      end
    end else begin
      w_seg = digit_seg(r_units);
    end
  end

  assign seg   = w_seg;
  assign an    = r_sel ? 2'b10 : 2'b01;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_bcd_display_driver.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_driver
//
// Two instances (leading-zero blanking on and off) share all inputs. The
// stimulus holds each value for one full 9-cycle sample period and pushes the
// value into a scoreboard queue; a monitor pops it whenever valid rises and
// checks digits, and every cycle checks seg/an/valid/ovf against a model built
// from decimal arithmetic, a cycle count since reset and the digit table.
// -----------------------------------------------------------------------------
module tb_bcd_display_driver;

  localparam int REF = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [6:0] bin;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       valid_a, valid_b;
  logic       ovf_a, ovf_b;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  always #5 clk = ~clk;

  bcd_display_driver #(.REFRESH(REF), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .clr(clr), .bin(bin),
    .seg(seg_a), .an(an_a), .valid(valid_a), .ovf(ovf_a)
  );

  bcd_display_driver #(.REFRESH(REF), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .clr(clr), .bin(bin),
    .seg(seg_b), .an(an_b), .valid(valid_b), .ovf(ovf_b)
  );

  // Expected segment pattern for a committed value on the selected digit.
  function automatic int model_seg(input int val, input bit sel, input bit blz);
    int t;
    int u;
    if (val > 99) return 1;
    t = val / 10;
    u = val % 10;
    if (!sel) return int'(DIGIT_SEG[u]);
    if (blz && t == 0) return 0;
    return int'(DIGIT_SEG[t]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  // One full sample period holding val at the LOAD edge; optional junk on bin afterwards.
  task automatic apply(input int val, input bit jitter);
    bin = 7'(val);
    exp_q.push_back(val);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (jitter) bin = 7'($urandom_range(0, 127));
    end
  endtask

  // Start a conversion and hit clr on the 4th SHIFT edge; no result is expected.
  task automatic abort_conv(input int val);
    bin = 7'(val);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Monitor: cycle-count model of the display plus scoreboard pops on valid.
  initial begin : monitor
    int c;
    int v;
    bit started;
    bit clr_s;
    bit m_sel;
    c = 0;
    v = 0;
    started = 1'b0;
    forever begin
      @(posedge clk);
      clr_s = clr;
      #1;
      if (clr_s) begin
        started = 1'b1;
        c = 0;
        v = 0;
      end else if (started) begin
        c++;
        if (valid_a) begin
          if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check("units", int'(dut.r_units), v % 10);
            check("tens", int'(dut.r_tens), (v / 10) % 10);
          end else begin
            check("unexpected_valid", 1, 0);
          end
        end
      end
      if (started) begin
        m_sel = ((c / REF) % 2) == 1;
        check("valid_a", int'(valid_a), (c > 0 && c % 9 == 0) ? 1 : 0);
        check("valid_b", int'(valid_b), (c > 0 && c % 9 == 0) ? 1 : 0);
        check("ovf_a", int'(ovf_a), (v > 99) ? 1 : 0);
        check("ovf_b", int'(ovf_b), (v > 99) ? 1 : 0);
        check("an_a", int'(an_a), m_sel ? 2 : 1);
        check("an_b", int'(an_b), m_sel ? 2 : 1);
        check("seg_blank", int'(seg_a), model_seg(v, m_sel, 1'b1));
        check("seg_noblank", int'(seg_b), model_seg(v, m_sel, 1'b0));
      end
    end
  end

  // Stimulus: directed cases, a down-count from 99, an aborted conversion, random values.
  initial begin : stim
    clr = 1'b1;
    bin = 7'd0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    apply(0, 1'b0);
    apply(42, 1'b0);
    for (int k = 99; k >= 0; k--) apply(k, 1'b0);
    apply(7, 1'b0);
    apply(127, 1'b0);
    apply(100, 1'b0);
    apply(99, 1'b0);
    abort_conv(55);
    apply(55, 1'b0);
    for (int k = 0; k < 40; k++) apply(int'($urandom_range(0, 127)), 1'b1);
    apply(0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
